// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the step sequencer: control-state encodings,
// instruction field positions and the HLT opcode pattern.
package step_sequencer_pkg;

  // Control states of the sequencer
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } seq_state_t;

  // Field positions of the major (InsM) and minor (InsL) opcode fields
  localparam int INSM_HI = 15;
  localparam int INSM_LO = 11;
  localparam int INSL_HI = 1;
  localparam int INSL_LO = 0;

  // HLT encoding: InsM=11100, InsL=01
  localparam logic [4:0] HLT_INSM = 5'b11100;
  localparam logic [1:0] HLT_INSL = 2'b01;

  // True when the given major/minor opcode fields encode HLT
  function automatic logic is_hlt(input logic [4:0] ins_m, input logic [1:0] ins_l);
    return (ins_m == HLT_INSM) && (ins_l == HLT_INSL);
  endfunction

endpackage

// File: rtl/step_sequencer_step_counter.sv
// Small step counter with synchronous clear and increment; holds otherwise.
module step_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         hold,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Reset and clear dominate, hold freezes, increment advances by one
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Per-instruction step sequencer: fetches into IR, steps Cnt until the
// decoder signals the last step, counts retirements, halts on HLT and
// faults when an instruction runs past the last legal step.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int CNT_W    = 3,
  parameter int MAX_STEP = 7,
  parameter int IR_W     = 16,
  parameter int RET_W    = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [IR_W-1:0]  Mem_Data,
  input  logic             Mem_Ready,
  input  logic             Buff_PC,
  output logic [CNT_W-1:0] Cnt,
  output logic             Fetch_En,
  output logic             IR_Load,
  output logic [IR_W-1:0]  IR,
  output logic [4:0]       InsM,
  output logic [1:0]       InsL,
  output logic             Halted,
  output logic             Fault,
  output logic [RET_W-1:0] Ret_Cnt
);

  localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(MAX_STEP);
  localparam logic [CNT_W-1:0] FIRST_EXEC = CNT_W'(2);

  seq_state_t state;
  seq_state_t next_state;

  logic cnt_clear;
  logic cnt_hold;
  logic cnt_inc;
  logic retire;

  step_counter #(
    .W (CNT_W)
  ) u_step_counter (
    .clk   (clk),
    .rst   (Rst),
    .clear (cnt_clear),
    .hold  (cnt_hold),
    .inc   (cnt_inc),
    .cnt   (Cnt)
  );

  assign InsM = IR[INSM_HI:INSM_LO];
  assign InsL = IR[INSL_HI:INSL_LO];

  // Next-state and step-control decode; RUN conditions are tested in priority order
  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    cnt_hold   = 1'b1;
    cnt_inc    = 1'b0;
    retire     = 1'b0;
    Fetch_En   = 1'b0;
    IR_Load    = 1'b0;
    case (state)
      ST_RUN: begin
        Fetch_En = (Cnt == '0);
        if (Cnt == '0) begin
          if (Mem_Ready) begin
            IR_Load  = 1'b1;
            cnt_hold = 1'b0;
            cnt_inc  = 1'b1;
          end
        end else if ((Cnt >= FIRST_EXEC) && Buff_PC) begin
          cnt_clear = 1'b1;
          retire    = 1'b1;
          if (is_hlt(InsM, InsL)) begin
            next_state = ST_HALT;
          end
        end else if (Cnt == LAST_STEP) begin
          next_state = ST_FAULT;
        end else begin
          cnt_hold = 1'b0;
          cnt_inc  = 1'b1;
        end
      end
      ST_HALT: begin
        cnt_clear = 1'b1;
      end
      ST_FAULT: begin
        cnt_hold = 1'b1;
      end
      default: begin
        next_state = ST_FAULT;
      end
    endcase
  end

  // State register with registered Halted/Fault flags that track the next state
  always_ff @(posedge clk) begin
    if (Rst) begin
      state  <= ST_RUN;
      Halted <= 1'b0;
      Fault  <= 1'b0;
    end else begin
      state  <= next_state;
      Halted <= (next_state == ST_HALT);
      Fault  <= (next_state == ST_FAULT);
    end
  end

  // Instruction register captures the fetched word on a completed fetch
  always_ff @(posedge clk) begin
    if (Rst) begin
      IR <= '0;
    end else if (IR_Load) begin
      IR <= Mem_Data;
    end
  end

  // Retired-instruction counter, wrapping naturally at all-ones
  always_ff @(posedge clk) begin
    if (Rst) begin
      Ret_Cnt <= '0;
    end else if (retire) begin
      Ret_Cnt <= Ret_Cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer. A second instance with a
// 4-bit retired counter shares every input so the wrap to zero is reachable.
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] Mem_Data = 16'h0000;
  logic        Mem_Ready = 1'b0;
  logic        Buff_PC = 1'b0;

  logic [2:0]  Cnt;
  logic        Fetch_En;
  logic        IR_Load;
  logic [15:0] IR;
  logic [4:0]  InsM;
  logic [1:0]  InsL;
  logic        Halted;
  logic        Fault;
  logic [15:0] Ret_Cnt;

  logic [2:0]  w_Cnt;
  logic        w_Fetch_En;
  logic        w_IR_Load;
  logic [15:0] w_IR;
  logic [4:0]  w_InsM;
  logic [1:0]  w_InsL;
  logic        w_Halted;
  logic        w_Fault;
  logic [3:0]  w_Ret_Cnt;

  int total = 0;
  int bad   = 0;

  step_sequencer dut (
    .clk       (clk),
    .Rst       (Rst),
    .Mem_Data  (Mem_Data),
    .Mem_Ready (Mem_Ready),
    .Buff_PC   (Buff_PC),
    .Cnt       (Cnt),
    .Fetch_En  (Fetch_En),
    .IR_Load   (IR_Load),
    .IR        (IR),
    .InsM      (InsM),
    .InsL      (InsL),
    .Halted    (Halted),
    .Fault     (Fault),
    .Ret_Cnt   (Ret_Cnt)
  );

  step_sequencer #(.RET_W(4)) dut_w (
    .clk       (clk),
    .Rst       (Rst),
    .Mem_Data  (Mem_Data),
    .Mem_Ready (Mem_Ready),
    .Buff_PC   (Buff_PC),
    .Cnt       (w_Cnt),
    .Fetch_En  (w_Fetch_En),
    .IR_Load   (w_IR_Load),
    .IR        (w_IR),
    .InsM      (w_InsM),
    .InsL      (w_InsL),
    .Halted    (w_Halted),
    .Fault     (w_Fault),
    .Ret_Cnt   (w_Ret_Cnt)
  );

  always #5 clk = ~clk;

  // Drive one set of inputs, take one rising edge, settle 1 time unit after it
  task automatic applyStimulus(input logic rst, input logic ready,
                               input logic [15:0] data, input logic buff);
    Rst       = rst;
    Mem_Ready = ready;
    Mem_Data  = data;
    Buff_PC   = buff;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    $display("[TB] start");
    // Initial reset
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("rst_cnt", 32'(Cnt), 32'd0);
    checkOutput("rst_fetch_en", 32'(Fetch_En), 32'd1);

    // T2: LHI fetch, retire at Cnt=2
    applyStimulus(1'b0, 1'b1, 16'h0800, 1'b0);
    checkOutput("t2_cnt1", 32'(Cnt), 32'd1);
    checkOutput("t2_ir", 32'(IR), 32'h0800);
    checkOutput("t2_insm", 32'(InsM), 32'b00001);
    checkOutput("t2_insl", 32'(InsL), 32'b00);
    applyStimulus(1'b0, 1'b0, 16'h0800, 1'b0);
    checkOutput("t2_cnt2", 32'(Cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 16'h0800, 1'b1);
    checkOutput("t2_cnt0", 32'(Cnt), 32'd0);
    checkOutput("t2_ret", 32'(Ret_Cnt), 32'd1);

    // T3: memory stall for 4 edges, then fetch completes
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h1234, 1'b0);
      checkOutput("t3_stall_cnt", 32'(Cnt), 32'd0);
      checkOutput("t3_stall_fetch_en", 32'(Fetch_En), 32'd1);
      checkOutput("t3_stall_ir", 32'(IR), 32'h0800);
    end
    Mem_Ready = 1'b1;
    #1;
    checkOutput("t3_ir_load", 32'(IR_Load), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
    checkOutput("t3_cnt1", 32'(Cnt), 32'd1);
    checkOutput("t3_ir", 32'(IR), 32'h1234);
    checkOutput("t3_insm", 32'(InsM), 32'b00010);
    checkOutput("t3_fetch_en_off", 32'(Fetch_En), 32'd0);

    // T6: Buff_PC at Cnt=1 is ignored; next step retires
    applyStimulus(1'b0, 1'b0, 16'h1234, 1'b1);
    checkOutput("t6_ignore_cnt", 32'(Cnt), 32'd2);
    checkOutput("t6_ignore_ret", 32'(Ret_Cnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h1234, 1'b1);
    checkOutput("t6_retire_cnt", 32'(Cnt), 32'd0);
    checkOutput("t6_retire_ret", 32'(Ret_Cnt), 32'd2);

    // T1: reset for 2 edges in the middle of an instruction at Cnt=3
    applyStimulus(1'b0, 1'b1, 16'h0800, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0800, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0800, 1'b0);
    checkOutput("t1_pre_cnt", 32'(Cnt), 32'd3);
    applyStimulus(1'b1, 1'b0, 16'h0800, 1'b1);
    checkOutput("t1_rst1_cnt", 32'(Cnt), 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h0800, 1'b1);
    checkOutput("t1_cnt", 32'(Cnt), 32'd0);
    checkOutput("t1_ir", 32'(IR), 32'h0000);
    checkOutput("t1_ret", 32'(Ret_Cnt), 32'd0);
    checkOutput("t1_halted", 32'(Halted), 32'd0);
    checkOutput("t1_fault", 32'(Fault), 32'd0);

    // T5: Buff_PC never arrives, runaway into FAULT at Cnt=7
    applyStimulus(1'b0, 1'b1, 16'h1000, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 16'h1000, 1'b0);
    checkOutput("t5_cnt7", 32'(Cnt), 32'd7);
    checkOutput("t5_no_fault_yet", 32'(Fault), 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 16'hE001, (i >= 3) ? 1'b1 : 1'b0);
      checkOutput("t5_fault", 32'(Fault), 32'd1);
      checkOutput("t5_cnt_hold", 32'(Cnt), 32'd7);
      checkOutput("t5_fetch_en", 32'(Fetch_En), 32'd0);
      checkOutput("t5_halted", 32'(Halted), 32'd0);
      checkOutput("t5_ret", 32'(Ret_Cnt), 32'd0);
      checkOutput("t5_ir", 32'(IR), 32'h1000);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("t5_rst_fault", 32'(Fault), 32'd0);
    checkOutput("t5_rst_cnt", 32'(Cnt), 32'd0);

    // T4: HLT retires and halts the sequencer
    applyStimulus(1'b0, 1'b1, 16'hE001, 1'b0);
    checkOutput("t4_insm", 32'(InsM), 32'b11100);
    checkOutput("t4_insl", 32'(InsL), 32'b01);
    applyStimulus(1'b0, 1'b0, 16'hE001, 1'b1);
    checkOutput("t4_cnt2", 32'(Cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 16'hE001, 1'b1);
    checkOutput("t4_halted", 32'(Halted), 32'd1);
    checkOutput("t4_cnt0", 32'(Cnt), 32'd0);
    checkOutput("t4_fetch_en", 32'(Fetch_En), 32'd0);
    checkOutput("t4_ret", 32'(Ret_Cnt), 32'd1);
    checkOutput("t4_fault", 32'(Fault), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0800, 1'b1);
      checkOutput("t4_hold_halted", 32'(Halted), 32'd1);
      checkOutput("t4_hold_cnt", 32'(Cnt), 32'd0);
      checkOutput("t4_hold_ir", 32'(IR), 32'hE001);
      checkOutput("t4_hold_ret", 32'(Ret_Cnt), 32'd1);
      checkOutput("t4_hold_ir_load", 32'(IR_Load), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("t4_rst_halted", 32'(Halted), 32'd0);
    checkOutput("t4_rst_cnt", 32'(Cnt), 32'd0);
    Rst = 1'b0;
    #1;
    checkOutput("t4_rst_fetch_en", 32'(Fetch_En), 32'd1);

    // Retired-counter wrap: 16 three-step instructions wrap the 4-bit counter
    for (int n = 1; n <= 16; n++) begin
      applyStimulus(1'b0, 1'b1, 16'h0800, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0800, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0800, 1'b1);
      if (n == 15) begin
        checkOutput("wrap_w_ret15", 32'(w_Ret_Cnt), 32'hF);
      end
    end
    checkOutput("wrap_ret16", 32'(Ret_Cnt), 32'd16);
    checkOutput("wrap_w_ret0", 32'(w_Ret_Cnt), 32'h0);
    checkOutput("wrap_cnt", 32'(Cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
